ledger_mem_responder: RTL and testbench
=======================================

# ledger_mem_responder

Memory-side responder for the 48-bit ledger word interface driven by the memory controller FSM. It accepts single-word read and write requests from one initiator over a ready/request handshake. It serves reads with a fixed, parameterised latency and acknowledges writes. After reset it can optionally sweep the array to zero before accepting traffic. It sits between the memory controller and the ledger storage array, replacing the controller's fixed wait counters with an explicit handshake.

## Interface
- `DATA_W`, 48, word width in bits.
- `ADDR_W`, 4, address width; `DEPTH = 2**ADDR_W` words.
- `READ_LATENCY`, 3, cycles from read accept to `data_valid`; legal range 1..7.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: request strobe; accepted only when `ready` is 1.
- `write_enable` in 1: 1 = write, 0 = read; sampled at accept.
- `access_type` in 1: 0 = full word; 1 = low half (bits 23:0); sampled at accept.
- `address` in ADDR_W: word address; sampled at accept.
- `data_in` in DATA_W: write data; sampled at accept.
- `ready` out 1: responder can accept a request this cycle.
- `data_out` out DATA_W: read data; holds its value until the next read completes.
- `data_valid` out 1: one-cycle pulse; `data_out` is valid this cycle.
- `write_ack` out 1: one-cycle pulse; the write has committed.
- `init_done` out 1: high once the array is usable; stays high until the next reset.

## Operation
- **Accept.** A request is accepted when `req && ready` is true at a clock edge. `write_enable`, `access_type`, `address` and `data_in` are registered at that edge. `req` while `ready` is 0 is ignored (not queued).
- **States.** CLEAR, IDLE, READ_WAIT, WRITE.
- **CLEAR**
  - Zeroes address 0..DEPTH-1, one word per cycle, for DEPTH cycles.
  - `ready` = 0 throughout.
  - Moves to IDLE after the write to DEPTH-1, and `init_done` rises on that same edge.
- **IDLE**
  - `ready` = 1.
  - An accepted read goes to READ_WAIT.
  - An accepted write goes to WRITE.
- **READ_WAIT**
  - A 3-bit counter loads 1 at accept and increments each cycle.
  - When the counter equals READ_LATENCY: `data_out` is loaded, `data_valid` pulses and `ready` = 1, so a back-to-back request can be accepted in that cycle.
  - Without a new request, the next state is IDLE.
- **Read data.**
  - `access_type` = 0: `data_out` = mem[addr].
  - `access_type` = 1: `data_out` = {24'b0, mem[addr][23:0]} (zero-extended).
- **WRITE**
  - Memory is updated at the accept edge.
  - `access_type` = 0: the full word is replaced.
  - `access_type` = 1: bits 23:0 are replaced and bits 47:24 are preserved (read-modify-write inside the array).
  - One cycle in WRITE: `write_ack` = 1, `ready` = 0. Then IDLE.
- **Read-after-write.** A read accepted after `write_ack` returns the new data.
- **Address range.** Addresses are always in range (full power-of-two decode); there is no wrap-around case.
- **Unused outputs.** `data_valid` and `write_ack` are never high simultaneously. Both are 0 in CLEAR and IDLE.

## Timing
- **Reset values.**
  - `data_out` = 0, `data_valid` = 0, `write_ack` = 0.
  - With `LEDGER_MEM_CLEAR_ON_RESET_EN`: state = CLEAR, `ready` = 0, `init_done` = 0.
  - Without it: state = IDLE, `ready` = 1, `init_done` = 1.
- **Read.** Accept at edge T; `data_valid` is high in the cycle after edge T+READ_LATENCY-1. With READ_LATENCY = 1, that is the cycle immediately after accept.
- **Write.** Accept at edge T; memory is updated at T. `write_ack` is high in the cycle after T. Maximum write rate is one per 2 cycles.
- **Reset mid-operation.** Reset has priority over every state. A pending read is dropped with no `data_valid`, and the latency counter clears. A write already accepted stays committed, but no `write_ack` is issued. CLEAR restarts from address 0 when the macro is enabled.
- **Simultaneous events.** `reset` and `req` in the same cycle: reset wins and the request is not accepted.

## Configuration
- `LEDGER_MEM_CLEAR_ON_RESET_EN` defined: the CLEAR state and its sweep address counter are compiled in. Reset zeroes the whole array, with DEPTH cycles of `ready` = 0.
- Undefined: no CLEAR state. Reset goes directly to IDLE with `init_done` = 1, and array contents are undefined/retained.

## Test plan
- **Reset sweep** (macro on, DEPTH = 16): assert `reset` 1 cycle → `ready` = 0 for 16 cycles, `init_done` rises on cycle 16. Reading each address 0..15 → `data_out` = 0.
- **Full write then read** (READ_LATENCY = 3): write 48'hA5A5_1234_5678 @ addr 5 → `write_ack` pulse the next cycle. Read addr 5 → `data_valid` 3 cycles after accept, `data_out` = 48'hA5A5_1234_5678.
- **Half-word access:** write 48'hFFFF_FFFF_FFFF @ 2, then half-write 24'h000123 @ 2 → full read = 48'hFFFF_FF00_0123. Half read = 48'h0000_0000_0123.
- **Back-to-back reads:** hold `req` high with addrs 1, 2 → second accept occurs in the first `data_valid` cycle. Two `data_valid` pulses 3 cycles apart.
- **Ignored request:** `req` during WRITE or READ_WAIT with `ready` = 0 → no extra `data_valid` or `write_ack`, and memory is unchanged.
- **Reset mid-read:** accept a read, assert `reset` on the next cycle → no `data_valid` ever appears, `data_out` = 0, and the CLEAR sweep restarts.

Source files
------------

// File: rtl/ledger_mem_responder_if.sv
// Request/response bundle between the memory controller and the ledger word responder.
interface ledger_mem_responder_if #(
  parameter int unsigned DATA_W = 48,
  parameter int unsigned ADDR_W = 4
);
  logic              req;
  logic              write_enable;
  logic              access_type;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              write_ack;
  logic              init_done;

  modport master (
    output req, write_enable, access_type, address, data_in,
    input  ready, data_out, data_valid, write_ack, init_done
  );

  modport slave (
    input  req, write_enable, access_type, address, data_in,
    output ready, data_out, data_valid, write_ack, init_done
  );
endinterface

// File: rtl/ledger_mem_responder.sv
// Ledger word responder: fixed-latency reads, acknowledged writes, half-word access.
// Define LEDGER_MEM_CLEAR_ON_RESET_EN to zero the array after every reset.
module ledger_mem_responder #(
  parameter int unsigned DATA_W       = 48,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned READ_LATENCY = 3
) (
  input logic                   clock,
  input logic                   reset,
  ledger_mem_responder_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned HalfW = 24;
  localparam logic [2:0]  RdLat = 3'(READ_LATENCY);

`ifdef LEDGER_MEM_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {StClear, StIdle, StReadWait, StWrite} state_e;
`else
  typedef enum logic [1:0] {StIdle, StReadWait, StWrite} state_e;
`endif

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_half_q;
  logic              ready_q;
  logic              init_done_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              write_ack_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef LEDGER_MEM_CLEAR_ON_RESET_EN
  logic [ADDR_W-1:0] clr_addr_q;
`endif

  logic accept;
  assign accept = bus.req && ready_q && !reset;

  function automatic logic [DATA_W-1:0] fetch(input logic [DATA_W-1:0] word, input logic half);
    return half ? {{(DATA_W - HalfW){1'b0}}, word[HalfW-1:0]} : word;
  endfunction

  // Storage: writes commit on the accept edge, independent of later resets.
  always_ff @(posedge clock) begin
`ifdef LEDGER_MEM_CLEAR_ON_RESET_EN
    if (!reset && state_q == StClear) begin
      mem_q[clr_addr_q] <= '0;
    end
`endif
    if (accept && bus.write_enable) begin
      if (bus.access_type) begin
        mem_q[bus.address] <= {mem_q[bus.address][DATA_W-1:HalfW], bus.data_in[HalfW-1:0]};
      end else begin
        mem_q[bus.address] <= bus.data_in;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef LEDGER_MEM_CLEAR_ON_RESET_EN
      state_q     <= StClear;
      clr_addr_q  <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
`else
      state_q     <= StIdle;
      ready_q     <= 1'b1;
      init_done_q <= 1'b1;
`endif
      cnt_q        <= '0;
      rd_addr_q    <= '0;
      rd_half_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      write_ack_q  <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      write_ack_q  <= 1'b0;
      unique case (state_q)
`ifdef LEDGER_MEM_CLEAR_ON_RESET_EN
        StClear: begin
          clr_addr_q <= clr_addr_q + ADDR_W'(1);
          if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
            state_q     <= StIdle;
            ready_q     <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
`endif
        StIdle: ;
        StReadWait: begin
          if (cnt_q == RdLat) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if ((cnt_q + 3'd1) == RdLat) begin
              data_out_q   <= fetch(mem_q[rd_addr_q], rd_half_q);
              data_valid_q <= 1'b1;
              ready_q      <= 1'b1;
            end
          end
        end
        StWrite: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase

      // A new request overrides the idle/return-to-idle decisions above.
      if (accept) begin
        rd_addr_q <= bus.address;
        rd_half_q <= bus.access_type;
        if (bus.write_enable) begin
          state_q     <= StWrite;
          write_ack_q <= 1'b1;
          ready_q     <= 1'b0;
        end else begin
          state_q <= StReadWait;
          cnt_q   <= 3'd1;
          if (RdLat == 3'd1) begin
            data_out_q   <= fetch(mem_q[bus.address], bus.access_type);
            data_valid_q <= 1'b1;
            ready_q      <= 1'b1;
          end else begin
            ready_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.ready      = ready_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.write_ack  = write_ack_q;
  assign bus.init_done  = init_done_q;
endmodule

// File: tb/tb_ledger_mem_responder.sv
// Self-checking bench for ledger_mem_responder: vector table, random traffic, corner sequences.
module tb_ledger_mem_responder;
  localparam int RL = 3;
`ifdef LEDGER_MEM_CLEAR_ON_RESET_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ledger_mem_responder_if #(.DATA_W(48), .ADDR_W(4)) bus ();

  ledger_mem_responder #(.DATA_W(48), .ADDR_W(4), .READ_LATENCY(RL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        we;
    logic        half;
    logic [3:0]  addr;
    logic [47:0] din;
    logic [47:0] exp;
  } vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [47:0] model [16];
  vec_t        vecs [12];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] merged(input logic [47:0] old, input logic [47:0] d,
                                         input logic h);
    if (h) return (old & 48'hFFFF_FF00_0000) | (d & 48'h0000_00FF_FFFF);
    return d;
  endfunction

  function automatic logic [47:0] expect_rd(input logic [47:0] word, input logic h);
    return h ? (word & 48'h0000_00FF_FFFF) : word;
  endfunction

  task automatic wait_ready(input string tag);
    int g = 0;
    while (bus.ready !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    if (bus.ready !== 1'b1) begin
      n_chk++;
      n_err++;
      $display("FAIL %s ready_timeout: got %b required 1", tag, bus.ready);
    end
  endtask

  task automatic do_write(input string tag, input logic [3:0] a, input logic h,
                          input logic [47:0] d);
    wait_ready(tag);
    bus.req = 1'b1; bus.write_enable = 1'b1; bus.access_type = h;
    bus.address = a; bus.data_in = d;
    tick();
    bus.req = 1'b0;
    check({tag, " write_ack"}, 48'(bus.write_ack), 48'd1);
    model[a] = merged(model[a], d, h);
  endtask

  task automatic do_read(input string tag, input logic [3:0] a, input logic h,
                         output logic [47:0] data);
    int lat = 1;
    int wa  = 0;
    wait_ready(tag);
    bus.req = 1'b1; bus.write_enable = 1'b0; bus.access_type = h; bus.address = a;
    tick();
    bus.req = 1'b0;
    while (bus.data_valid !== 1'b1 && lat < 20) begin
      wa += int'(bus.write_ack);
      tick();
      lat++;
    end
    data = bus.data_out;
    check({tag, " latency"}, 48'(lat), 48'(RL));
    check({tag, " no_ack"}, 48'(wa), 48'd0);
  endtask

  // One reset edge, then watch 24 cycles of the sweep / idle behaviour.
  task automatic do_reset(input string tag, input logic with_req);
    int low = 0, dv = 0, wa = 0, init_at = -1;
    bus.req = with_req; bus.write_enable = 1'b1; bus.access_type = 1'b0;
    bus.address = 4'd9; bus.data_in = 48'h1357_9BDF_2468;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req = 1'b0;
    check({tag, " rst data_out"}, bus.data_out, 48'd0);
    check({tag, " rst data_valid"}, 48'(bus.data_valid), 48'd0);
    check({tag, " rst write_ack"}, 48'(bus.write_ack), 48'd0);
    check({tag, " rst ready"}, 48'(bus.ready), 48'(!ClearEn));
    check({tag, " rst init_done"}, 48'(bus.init_done), 48'(!ClearEn));
    for (int i = 0; i < 24; i++) begin
      if (bus.ready !== 1'b1) low++;
      if (bus.init_done === 1'b1 && init_at < 0) init_at = i;
      dv += int'(bus.data_valid);
      wa += int'(bus.write_ack);
      tick();
    end
    check({tag, " ready_low_cycles"}, 48'(low), ClearEn ? 48'd16 : 48'd0);
    check({tag, " init_done_cycle"}, 48'(init_at), ClearEn ? 48'd16 : 48'd0);
    check({tag, " no_data_valid"}, 48'(dv), 48'd0);
    check({tag, " no_write_ack"}, 48'(wa), 48'd0);
    check({tag, " data_out_zero"}, bus.data_out, 48'd0);
    if (ClearEn) for (int k = 0; k < 16; k++) model[k] = 48'd0;
  endtask

  logic [47:0] rdata, rdata2;
  logic [3:0]  ra;
  logic        rw, rh;
  logic [47:0] rd;
  int          t, dvc, wac;

  initial begin
    bus.req = 1'b0; bus.write_enable = 1'b0; bus.access_type = 1'b0;
    bus.address = '0; bus.data_in = '0;

    vecs[0]  = '{1'b1, 1'b0, 4'd5,  48'hA5A5_1234_5678, 48'h0};
    vecs[1]  = '{1'b0, 1'b0, 4'd5,  48'h0,              48'hA5A5_1234_5678};
    vecs[2]  = '{1'b1, 1'b0, 4'd2,  48'hFFFF_FFFF_FFFF, 48'h0};
    vecs[3]  = '{1'b1, 1'b1, 4'd2,  48'hABCD_EF00_0123, 48'h0};
    vecs[4]  = '{1'b0, 1'b0, 4'd2,  48'h0,              48'hFFFF_FF00_0123};
    vecs[5]  = '{1'b0, 1'b1, 4'd2,  48'h0,              48'h0000_0000_0123};
    vecs[6]  = '{1'b1, 1'b1, 4'd5,  48'h0,              48'h0};
    vecs[7]  = '{1'b0, 1'b0, 4'd5,  48'h0,              48'hA5A5_1200_0000};
    vecs[8]  = '{1'b0, 1'b1, 4'd5,  48'h0,              48'h0};
    vecs[9]  = '{1'b1, 1'b0, 4'd15, 48'h8000_0000_0001, 48'h0};
    vecs[10] = '{1'b0, 1'b0, 4'd15, 48'h0,              48'h8000_0000_0001};
    vecs[11] = '{1'b0, 1'b1, 4'd15, 48'h0,              48'h0000_0000_0001};

    do_reset("init", 1'b0);
    if (ClearEn) begin
      for (int k = 0; k < 16; k++) begin
        do_read("sweep", 4'(k), 1'b0, rdata);
        check("sweep zero", rdata, 48'd0);
      end
    end

    // Known contents everywhere so later reads never touch unwritten words.
    for (int k = 0; k < 16; k++) do_write("fill", 4'(k), 1'b0, {16'($urandom), $urandom});

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].we) begin
        do_write($sformatf("vec%0d", v), vecs[v].addr, vecs[v].half, vecs[v].din);
      end else begin
        do_read($sformatf("vec%0d", v), vecs[v].addr, vecs[v].half, rdata);
        check($sformatf("vec%0d data", v), rdata, vecs[v].exp);
      end
    end

    for (int n = 0; n < 150; n++) begin
      rw = 1'($urandom);
      rh = 1'($urandom);
      ra = 4'($urandom_range(0, 15));
      rd = {16'($urandom), $urandom};
      if (rw) begin
        do_write("rand", ra, rh, rd);
      end else begin
        do_read("rand", ra, rh, rdata);
        check($sformatf("rand rd a=%0d h=%0b", ra, rh), rdata, expect_rd(model[ra], rh));
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    // Back-to-back reads: second accept lands in the first data_valid cycle.
    wait_ready("b2b");
    bus.req = 1'b1; bus.write_enable = 1'b0; bus.access_type = 1'b0; bus.address = 4'd1;
    tick();
    bus.address = 4'd2;
    t = 1;
    while (bus.data_valid !== 1'b1 && t < 20) begin tick(); t++; end
    check("b2b first latency", 48'(t), 48'(RL));
    check("b2b first data", bus.data_out, model[1]);
    check("b2b ready in valid cycle", 48'(bus.ready), 48'd1);
    tick();
    bus.req = 1'b0;
    t = 1;
    while (bus.data_valid !== 1'b1 && t < 20) begin tick(); t++; end
    check("b2b spacing", 48'(t), 48'(RL));
    check("b2b second data", bus.data_out, model[2]);

    // Requests while ready is low are dropped.
    do_write("ign", 4'd7, 1'b0, 48'h0BAD_CAFE_0007);
    check("ign ready low in write", 48'(bus.ready), 48'd0);
    wac = int'(bus.write_ack);
    bus.req = 1'b1; bus.write_enable = 1'b1; bus.access_type = 1'b0;
    bus.address = 4'd7; bus.data_in = 48'hDEAD_DEAD_DEAD;
    tick();
    bus.req = 1'b0;
    for (int i = 0; i < 4; i++) begin wac += int'(bus.write_ack); tick(); end
    check("ign write_ack count", 48'(wac), 48'd1);
    wait_ready("ign rd");
    bus.req = 1'b1; bus.write_enable = 1'b0; bus.access_type = 1'b0; bus.address = 4'd7;
    tick();
    dvc = 0;
    wac = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.ready === 1'b1) begin
        bus.req = 1'b0;
      end else begin
        bus.req = 1'b1; bus.write_enable = 1'b1; bus.address = 4'd7;
        bus.data_in = 48'hBEEF_BEEF_BEEF;
      end
      dvc += int'(bus.data_valid);
      wac += int'(bus.write_ack);
      if (bus.data_valid === 1'b1) rdata2 = bus.data_out;
      tick();
    end
    bus.req = 1'b0;
    check("ign data_valid count", 48'(dvc), 48'd1);
    check("ign stray write_ack", 48'(wac), 48'd0);
    check("ign read data", rdata2, 48'h0BAD_CAFE_0007);
    do_read("ign after", 4'd7, 1'b0, rdata);
    check("ign mem unchanged", rdata, 48'h0BAD_CAFE_0007);

    // Reset one cycle after a read accept.
    wait_ready("midrd");
    bus.req = 1'b1; bus.write_enable = 1'b0; bus.access_type = 1'b0; bus.address = 4'd3;
    tick();
    do_reset("midrd", 1'b0);

    // Reset and a write request in the same cycle: the write must not land.
    do_reset("rstreq", 1'b1);
    do_read("rstreq", 4'd9, 1'b0, rdata);
    check("rstreq addr9", rdata, model[9]);
    do_read("rstreq", 4'd5, 1'b1, rdata);
    check("rstreq addr5 half", rdata, expect_rd(model[5], 1'b1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
